bullet_pool: RTL

BULLET_POOL -- requirements
Module: bullet_pool

---
 rtl/bullet_pool.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bullet_pool.sv
// Player bullet pool: fixed slots fired from the muzzle, moving up per game tick,
// retired on leaving the top edge or on hitting the target box, plus pixel overlay.

module bullet_slot #(
  parameter int BW    = 4,
  parameter int BH    = 16,
  parameter int SPEED = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic [9:0] t_x,
  input  logic [9:0] t_y,
  input  logic [9:0] t_w,
  input  logic [9:0] t_h,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       active,
  output logic       hit,
  output logic       covers
);

  logic [9:0]  b_x, b_y, moved_y;
  logic        off_top, tgt_valid, overlap;
  logic [10:0] bx, my, tx, ty, px, py;

  assign off_top   = b_y < 10'(SPEED);
  assign moved_y   = b_y - 10'(SPEED);
  assign tgt_valid = (t_w != '0) && (t_h != '0);

  // all box math in 11 bits so right/bottom edges never wrap
  assign bx = {1'b0, b_x};
  assign my = {1'b0, moved_y};
  assign tx = {1'b0, t_x};
  assign ty = {1'b0, t_y};
  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};

  assign overlap = (bx < tx + {1'b0, t_w}) && (tx < bx + 11'(BW)) &&
                   (my < ty + {1'b0, t_h}) && (ty < my + 11'(BH));

  assign hit = tick && active && !off_top && tgt_valid && overlap;

  assign covers = active && (px >= bx) && (px < bx + 11'(BW)) &&
                  (py >= {1'b0, b_y}) && (py < {1'b0, b_y} + 11'(BH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= 1'b0;
      b_x    <= '0;
      b_y    <= '0;
    end else if (tick) begin
      if (active) begin
        if (off_top || hit) active <= 1'b0;
        else                b_y    <= moved_y;
      end else if (spawn) begin
        active <= 1'b1;
        b_x    <= spawn_x;
        b_y    <= spawn_y;
      end
    end
  end

endmodule

module bullet_pool #(
  parameter int          N_BULLETS = 4,
  parameter int          BW        = 4,
  parameter int          BH        = 16,
  parameter int          SPEED     = 4,
  parameter int          COOLDOWN  = 8,
  parameter logic [11:0] COLOR     = 12'h00F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 fire,
  input  logic [9:0]           p_x,
  input  logic [9:0]           p_y,
  input  logic [9:0]           t_x,
  input  logic [9:0]           t_y,
  input  logic [9:0]           t_w,
  input  logic [9:0]           t_h,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  output logic                 bullet_en,
  output logic [11:0]          bullet_rgb,
  output logic [N_BULLETS-1:0] active_mask,
  output logic                 hit,
  output logic [7:0]           hit_count
);

  logic [N_BULLETS-1:0] slot_act, slot_hit, slot_cov, free_sel, spawn;
  logic [7:0]           cooldown;
  logic                 fire_ok, any_free;
  logic [9:0]           spawn_y;

  // lowest free slot, judged on state at the start of the tick
  always_comb begin
    free_sel = '0;
    any_free = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!slot_act[i] && !any_free) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  assign fire_ok = tick && fire && (cooldown == 8'd0) &&
                   ({1'b0, p_y} >= 11'(BH)) && any_free;
  assign spawn   = fire_ok ? free_sel : '0;
  assign spawn_y = p_y - 10'(BH);

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
    bullet_slot #(.BW(BW), .BH(BH), .SPEED(SPEED)) u_slot (
      .clk(clk), .rst(rst), .tick(tick), .spawn(spawn[g]),
      .spawn_x(p_x), .spawn_y(spawn_y),
      .t_x(t_x), .t_y(t_y), .t_w(t_w), .t_h(t_h),
      .pix_x(pix_x), .pix_y(pix_y),
      .active(slot_act[g]), .hit(slot_hit[g]), .covers(slot_cov[g])
    );
  end

  assign active_mask = slot_act;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cooldown   <= '0;
      hit        <= 1'b0;
      hit_count  <= '0;
      bullet_en  <= 1'b0;
      bullet_rgb <= '0;
    end else begin
      bullet_en  <= |slot_cov;
      bullet_rgb <= (|slot_cov) ? COLOR : 12'h000;
      hit        <= tick && (|slot_hit);
      if (tick) begin
        if (fire_ok)               cooldown <= 8'(COOLDOWN);
        else if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
        if (|slot_hit) hit_count <= hit_count + 8'd1;
      end
    end
  end

endmodule
